// File: rtl/dma_seq_pkg.sv
// Shared types for the DMA descriptor sequencer: FSM state encoding and
// bit positions inside the DMA control register.
package dma_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_MIN,
    ST_WR_MAX,
    ST_WR_ADDR,
    ST_WR_LEN,
    ST_WR_CTRL,
    ST_WAIT,
    ST_ABORT
  } state_e;

  localparam int CTRL_START = 0;
  localparam int CTRL_STOP  = 1;
  localparam int CTRL_DIR   = 2;
  localparam int CTRL_MODE  = 3;

  // Descriptor programming states; ABORT also writes but never chains to a next write.
  function automatic logic is_desc_write(input state_e s);
    return (s == ST_WR_MIN) || (s == ST_WR_MAX) || (s == ST_WR_ADDR) ||
           (s == ST_WR_LEN) || (s == ST_WR_CTRL);
  endfunction

endpackage

// File: rtl/dma_desc_sequencer.sv
// Descriptor front end for the DMA: programs window/address/length/control
// registers per descriptor, waits for completion, and handles abort/timeout.
//
// state      | meaning
// IDLE       | ready for a descriptor; zero-length descriptors retire here
// WR_MIN     | writing min_addr window bound
// WR_MAX     | writing max_addr window bound
// WR_ADDR    | writing DMA start address
// WR_LEN     | writing transfer length
// WR_CTRL    | writing control word with start set
// WAIT       | transfer running, waiting for dma_finish / abort / timeout
// ABORT      | writing control word with stop set, then retire
import dma_seq_pkg::*;

module dma_desc_sequencer #(
  parameter int          REGS_DW  = 32,
  parameter int          REGS_AW  = 4,
  parameter int          REG_MIN  = 0,
  parameter int          REG_MAX  = 1,
  parameter int          REG_ADDR = 2,
  parameter int          REG_LEN  = 3,
  parameter int          REG_CTRL = 4,
  parameter int unsigned TIMEOUT  = 0,
  parameter int          CNT_W    = 16
) (
  input  logic               aclk,
  input  logic               areset,
  input  logic               desc_valid,
  output logic               desc_ready,
  input  logic [REGS_DW-1:0] desc_addr,
  input  logic [REGS_DW-1:0] desc_len,
  input  logic               desc_dir,
  input  logic               desc_mode,
  input  logic [REGS_DW-1:0] cfg_min_addr,
  input  logic [REGS_DW-1:0] cfg_max_addr,
  input  logic               abort,
  input  logic               err_clr,
  output logic               regs_we,
  output logic [REGS_AW-1:0] regs_addr,
  output logic [REGS_DW-1:0] regs_wdata,
  input  logic               regs_rdy,
  input  logic               dma_finish,
  output logic               busy,
  output logic               done,
  output logic               err_timeout,
  output logic [CNT_W-1:0]   desc_cnt
);

  localparam logic [31:0] TO_LAST = (TIMEOUT == 0) ? 32'd0 : 32'(TIMEOUT - 1);

  state_e state_q, state_d;

  logic [REGS_DW-1:0] addr_q, len_q, min_q, max_q;
  logic               dir_q, mode_q;
  logic               abort_pend_q;
  logic [31:0]        wait_cnt_q;
  logic               done_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               err_q;

  logic accept;
  logic wr_fire;
  logic abort_any;
  logic timeout_hit;
  logic retire;
  logic in_desc_wr;

  assign in_desc_wr = is_desc_write(state_q);
  assign accept     = desc_valid && desc_ready;
  assign wr_fire    = regs_we && regs_rdy;
  assign abort_any  = abort_pend_q || abort;

  // Timeout only counts when no finish arrives in the same cycle; finish has priority.
  assign timeout_hit = (TIMEOUT != 0) && (state_q == ST_WAIT) && !dma_finish &&
                       (wait_cnt_q == TO_LAST);

  assign retire = ((state_q == ST_WAIT) && dma_finish) ||
                  ((state_q == ST_ABORT) && wr_fire) ||
                  (accept && (desc_len == '0));

  // State register
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept && (desc_len != '0)) state_d = ST_WR_MIN;
      end
      ST_WR_MIN: begin
        if (wr_fire) state_d = abort_any ? ST_ABORT : ST_WR_MAX;
      end
      ST_WR_MAX: begin
        if (wr_fire) state_d = abort_any ? ST_ABORT : ST_WR_ADDR;
      end
      ST_WR_ADDR: begin
        if (wr_fire) state_d = abort_any ? ST_ABORT : ST_WR_LEN;
      end
      ST_WR_LEN: begin
        if (wr_fire) state_d = abort_any ? ST_ABORT : ST_WR_CTRL;
      end
      ST_WR_CTRL: begin
        if (wr_fire) state_d = abort_any ? ST_ABORT : ST_WAIT;
      end
      ST_WAIT: begin
        if (dma_finish) begin
          state_d = ST_IDLE;
        end else if (abort || timeout_hit) begin
          state_d = ST_ABORT;
        end
      end
      ST_ABORT: begin
        if (wr_fire) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic: register write mux and status
  always_comb begin
    regs_we    = 1'b0;
    regs_addr  = '0;
    regs_wdata = '0;
    case (state_q)
      ST_WR_MIN: begin
        regs_we    = 1'b1;
        regs_addr  = REGS_AW'(REG_MIN);
        regs_wdata = min_q;
      end
      ST_WR_MAX: begin
        regs_we    = 1'b1;
        regs_addr  = REGS_AW'(REG_MAX);
        regs_wdata = max_q;
      end
      ST_WR_ADDR: begin
        regs_we    = 1'b1;
        regs_addr  = REGS_AW'(REG_ADDR);
        regs_wdata = addr_q;
      end
      ST_WR_LEN: begin
        regs_we    = 1'b1;
        regs_addr  = REGS_AW'(REG_LEN);
        regs_wdata = len_q;
      end
      ST_WR_CTRL: begin
        regs_we                = 1'b1;
        regs_addr              = REGS_AW'(REG_CTRL);
        regs_wdata[CTRL_START] = 1'b1;
        regs_wdata[CTRL_DIR]   = dir_q;
        regs_wdata[CTRL_MODE]  = mode_q;
      end
      ST_ABORT: begin
        regs_we               = 1'b1;
        regs_addr             = REGS_AW'(REG_CTRL);
        regs_wdata[CTRL_STOP] = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy        = (state_q != ST_IDLE);
  assign desc_ready  = (state_q == ST_IDLE) && !abort;
  assign done        = done_q;
  assign err_timeout = err_q;
  assign desc_cnt    = cnt_q;

  // Datapath: descriptor latch, abort memory, wait timer, retire bookkeeping
  always_ff @(posedge aclk) begin
    if (areset) begin
      addr_q       <= '0;
      len_q        <= '0;
      min_q        <= '0;
      max_q        <= '0;
      dir_q        <= 1'b0;
      mode_q       <= 1'b0;
      abort_pend_q <= 1'b0;
      wait_cnt_q   <= '0;
      done_q       <= 1'b0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
    end else begin
      if (accept) begin
        addr_q <= desc_addr;
        len_q  <= desc_len;
        min_q  <= cfg_min_addr;
        max_q  <= cfg_max_addr;
        dir_q  <= desc_dir;
        mode_q <= desc_mode;
      end
      // An abort seen mid-write is remembered until that write completes.
      abort_pend_q <= in_desc_wr && !wr_fire && abort_any;
      wait_cnt_q   <= (state_q == ST_WAIT) ? wait_cnt_q + 32'd1 : 32'd0;
      done_q       <= retire;
      if (retire) cnt_q <= cnt_q + 1'b1;
      if (timeout_hit) begin
        err_q <= 1'b1;
      end else if (err_clr) begin
        err_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dma_desc_sequencer.sv
// Self-checking bench for dma_desc_sequencer: directed scenarios with literal
// expectations plus randomized traffic against a transaction-level model.
module tb_dma_desc_sequencer;

  localparam int TO = 8;

  typedef struct packed {
    logic [3:0]  a;
    logic [31:0] d;
  } wr_t;

  logic        aclk = 1'b0;
  logic        areset;
  logic        desc_valid, desc_ready;
  logic [31:0] desc_addr, desc_len;
  logic        desc_dir, desc_mode;
  logic [31:0] cfg_min_addr, cfg_max_addr;
  logic        abort, err_clr;
  logic        regs_we;
  logic [3:0]  regs_addr;
  logic [31:0] regs_wdata;
  logic        regs_rdy, dma_finish;
  logic        busy, done, err_timeout;
  logic [15:0] desc_cnt;

  always #5 aclk = ~aclk;

  dma_desc_sequencer #(.TIMEOUT(TO)) dut (
    .aclk(aclk), .areset(areset),
    .desc_valid(desc_valid), .desc_ready(desc_ready),
    .desc_addr(desc_addr), .desc_len(desc_len),
    .desc_dir(desc_dir), .desc_mode(desc_mode),
    .cfg_min_addr(cfg_min_addr), .cfg_max_addr(cfg_max_addr),
    .abort(abort), .err_clr(err_clr),
    .regs_we(regs_we), .regs_addr(regs_addr), .regs_wdata(regs_wdata),
    .regs_rdy(regs_rdy), .dma_finish(dma_finish),
    .busy(busy), .done(done), .err_timeout(err_timeout), .desc_cnt(desc_cnt)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: a descriptor in flight is a queue of pending register
  // writes; once the queue drains the transfer is waiting for completion.
  wr_t         wq[$];
  wr_t         wlog[$];
  bit          m_inflight, m_aborting, m_abort_pend, m_done, m_err;
  int          m_wait_n;
  logic [15:0] m_cnt;

  task automatic model_reset();
    wq.delete();
    m_inflight = 0; m_aborting = 0; m_abort_pend = 0; m_done = 0; m_err = 0;
    m_wait_n = 0; m_cnt = '0;
  endtask

  task automatic start_stop();
    wq.delete();
    wq.push_back('{4'd4, 32'h2});
    m_aborting   = 1;
    m_abort_pend = 0;
  endtask

  task automatic model_update();
    bit ev = 0;
    bit set_err = 0;
    if (areset) begin
      model_reset();
      return;
    end
    if (!m_inflight) begin
      if (desc_valid && !abort) begin
        if (desc_len == 0) ev = 1;
        else begin
          wq.push_back('{4'd0, cfg_min_addr});
          wq.push_back('{4'd1, cfg_max_addr});
          wq.push_back('{4'd2, desc_addr});
          wq.push_back('{4'd3, desc_len});
          wq.push_back('{4'd4, 32'd1 | (32'(desc_dir) << 2) | (32'(desc_mode) << 3)});
          m_inflight = 1; m_abort_pend = 0;
        end
      end
    end else if (wq.size() > 0) begin
      if (abort && !m_aborting) m_abort_pend = 1;
      if (regs_rdy) begin
        void'(wq.pop_front());
        if (m_aborting) begin
          m_aborting = 0; m_inflight = 0; ev = 1;
        end else if (m_abort_pend) begin
          start_stop();
        end else if (wq.size() == 0) begin
          m_wait_n = 0;
        end
      end
    end else begin
      if (dma_finish) begin
        m_inflight = 0; ev = 1;
      end else begin
        set_err = (m_wait_n == TO - 1);
        if (abort || set_err) start_stop();
        else m_wait_n++;
      end
    end
    if (set_err) m_err = 1;
    else if (err_clr) m_err = 0;
    m_done = ev;
    if (ev) m_cnt = m_cnt + 16'd1;
  endtask

  // One cycle: compare DUT against model, advance model, move to next negedge.
  task automatic step();
    bit exp_we;
    #1;
    exp_we = (wq.size() > 0);
    check("status", {busy, desc_ready, done, err_timeout},
          {m_inflight, !m_inflight && !abort, m_done, m_err});
    check("regs_we", regs_we, exp_we);
    if (exp_we) check("regs_wr", {regs_addr, regs_wdata}, {wq[0].a, wq[0].d});
    check("desc_cnt", desc_cnt, m_cnt);
    if (regs_we && regs_rdy) wlog.push_back('{regs_addr, regs_wdata});
    model_update();
    @(negedge aclk);
  endtask

  task automatic idle_inputs();
    areset = 0; desc_valid = 0; abort = 0; err_clr = 0; dma_finish = 0; regs_rdy = 1;
  endtask

  task automatic set_desc(input logic [31:0] a, input logic [31:0] l, input logic dr, input logic md);
    desc_valid = 1; desc_addr = a; desc_len = l; desc_dir = dr; desc_mode = md;
  endtask

  logic [3:0]  t1_a [5];
  logic [31:0] t1_d [5];
  int          n_addr2;

  initial begin
    idle_inputs();
    desc_addr = 0; desc_len = 0; desc_dir = 0; desc_mode = 0;
    cfg_min_addr = 32'h0; cfg_max_addr = 32'hFFFF;
    model_reset();
    @(negedge aclk);
    areset = 1;
    step(); step();
    areset = 0;
    check("rst_busy", busy, 0);
    check("rst_ready", desc_ready, 1);
    check("rst_we", regs_we, 0);
    check("rst_cnt", desc_cnt, 0);

    // Basic descriptor, back-to-back writes, finish in WAIT
    t1_a = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
    t1_d = '{32'h0, 32'hFFFF, 32'h1000, 32'd256, 32'h5};
    set_desc(32'h1000, 32'd256, 1'b1, 1'b0);
    step();
    desc_valid = 0;
    wlog.delete();
    repeat (5) step();
    check("t1_nwr", wlog.size(), 5);
    for (int i = 0; i < 5 && i < wlog.size(); i++)
      check($sformatf("t1_wr%0d", i), {wlog[i].a, wlog[i].d}, {t1_a[i], t1_d[i]});
    repeat (6) step();
    dma_finish = 1; step(); dma_finish = 0;
    check("t1_done", done, 1);
    check("t1_cnt", desc_cnt, 1);
    step();
    check("t1_done_once", done, 0);

    // Register port stalls during WR_ADDR
    set_desc(32'h1000, 32'd16, 1'b0, 1'b1);
    step();
    desc_valid = 0;
    wlog.delete();
    repeat (2) step();
    regs_rdy = 0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t2_hold%0d", i), {regs_we, regs_addr, regs_wdata}, {1'b1, 4'd2, 32'h1000});
      if (i < 3) step();
    end
    regs_rdy = 1;
    step();
    n_addr2 = 0;
    foreach (wlog[i]) if (wlog[i].a == 4'd2) n_addr2++;
    check("t2_one_addr_wr", n_addr2, 1);
    repeat (2) step();
    check("t2_ctrl", {wlog[wlog.size()-1].a, wlog[wlog.size()-1].d}, {4'd4, 32'h9});
    dma_finish = 1; step(); dma_finish = 0;

    // Timeout with no finish
    set_desc(32'h2000, 32'd8, 1'b1, 1'b1);
    step();
    desc_valid = 0;
    repeat (5) step();
    repeat (TO) step();
    check("t3_stop_wr", {regs_we, regs_addr, regs_wdata}, {1'b1, 4'd4, 32'h2});
    check("t3_err", err_timeout, 1);
    step();
    check("t3_done", done, 1);
    check("t3_cnt", desc_cnt, 3);
    err_clr = 1; step(); err_clr = 0;
    check("t3_err_clr", err_timeout, 0);

    // abort and finish together in WAIT: finish wins
    set_desc(32'h3000, 32'd32, 1'b0, 1'b0);
    step();
    desc_valid = 0;
    repeat (7) step();
    wlog.delete();
    abort = 1; dma_finish = 1; step(); abort = 0; dma_finish = 0;
    check("t4_done", done, 1);
    check("t4_busy", busy, 0);
    check("t4_cnt", desc_cnt, 4);
    repeat (3) step();
    check("t4_no_stop", wlog.size(), 0);

    // zero-length descriptor followed by a normal one
    areset = 1; step(); areset = 0;
    wlog.delete();
    set_desc(32'h4000, 32'd0, 1'b1, 1'b0);
    step();
    check("t5_done0", done, 1);
    check("t5_busy0", busy, 0);
    check("t5_nowr", wlog.size(), 0);
    set_desc(32'h5000, 32'd64, 1'b0, 1'b0);
    step();
    desc_valid = 0;
    repeat (5) step();
    check("t5_nwr", wlog.size(), 5);
    if (wlog.size() > 3) check("t5_len", wlog[3].d, 32'd64);
    dma_finish = 1; step(); dma_finish = 0;
    check("t5_cnt", desc_cnt, 2);

    // reset in the middle of programming
    set_desc(32'h6000, 32'd12, 1'b0, 1'b0);
    step();
    desc_valid = 0;
    repeat (3) step();
    check("t6_in_len", {regs_we, regs_addr}, {1'b1, 4'd3});
    areset = 1; step(); areset = 0;
    check("t6_we", regs_we, 0);
    check("t6_busy", busy, 0);
    check("t6_ready", desc_ready, 1);
    check("t6_cnt", desc_cnt, 0);

    // randomized traffic
    repeat (4000) begin
      areset       = ($urandom_range(399) == 0);
      desc_valid   = ($urandom_range(1) == 1);
      desc_addr    = $urandom;
      desc_len     = ($urandom_range(5) == 0) ? 32'd0 : $urandom;
      desc_dir     = 1'($urandom_range(1));
      desc_mode    = 1'($urandom_range(1));
      cfg_min_addr = $urandom;
      cfg_max_addr = $urandom;
      abort        = ($urandom_range(19) == 0);
      err_clr      = ($urandom_range(15) == 0);
      regs_rdy     = ($urandom_range(3) != 0);
      dma_finish   = ($urandom_range(9) == 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
